// File: rtl/wish_unpack_var.sv
// wish_unpack_var
//   Wishbone-style stream unpacker. Each accepted wide word of NUM_PACK lanes
//   is split into DATA_WIDTH-bit beats on the narrow destination port. Only
//   the first s_cnt_i lanes in the selected lane order are emitted. A
//   two-entry buffer (ACTIVE + PENDING) sustains one beat per cycle across
//   word boundaries.
//
// Ports
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   s_stb_i, s_cyc_i    source strobe / cycle
//   s_ack_o, s_stall_o  source accept / stall (stall = cyc & !ack)
//   s_dat_i             wide word, lane k at bits k*DATA_WIDTH +: DATA_WIDTH
//   s_cnt_i             valid lanes (0 or >NUM_PACK means NUM_PACK)
//   s_tgc_i             word tag: bit0 SOP, bit1 EOP, upper bits user sideband
//   d_stb_o, d_cyc_o    beat valid (identical)
//   d_ack_i             consumer takes beat
//   d_dat_o, d_tgc_o    beat data / beat tag
//   occ_o               words held (0..2)
module wish_unpack_var #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned NUM_PACK      = 4,
  parameter int unsigned TGC_WIDTH     = 2,
  parameter int unsigned LITTLE_ENDIAN = 1,
  parameter int unsigned CNT_W         = $clog2(NUM_PACK) + 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           s_stb_i,
  input  logic                           s_cyc_i,
  output logic                           s_ack_o,
  output logic                           s_stall_o,
  input  logic [DATA_WIDTH*NUM_PACK-1:0] s_dat_i,
  input  logic [CNT_W-1:0]               s_cnt_i,
  input  logic [TGC_WIDTH-1:0]           s_tgc_i,
  output logic                           d_stb_o,
  output logic                           d_cyc_o,
  input  logic                           d_ack_i,
  output logic [DATA_WIDTH-1:0]          d_dat_o,
  output logic [TGC_WIDTH-1:0]           d_tgc_o,
  output logic [1:0]                     occ_o
);

  localparam int unsigned WW = DATA_WIDTH * NUM_PACK;

  logic                 act_valid, act_valid_n;
  logic [WW-1:0]        act_dat, act_dat_n;
  logic [CNT_W-1:0]     act_cnt, act_cnt_n;
  logic [TGC_WIDTH-1:0] act_tag, act_tag_n;
  logic [CNT_W-1:0]     act_idx, act_idx_n;

  logic                 pend_valid, pend_valid_n;
  logic [WW-1:0]        pend_dat, pend_dat_n;
  logic [CNT_W-1:0]     pend_cnt, pend_cnt_n;
  logic [TGC_WIDTH-1:0] pend_tag, pend_tag_n;

  logic                 ack_q, ack_n;
  logic [CNT_W-1:0]     in_cnt;
  logic                 s_fire, beat_fire, last_beat;
  logic [31:0]          lane;

  // Lane count normalised once at acceptance so the beat logic only ever sees 1..NUM_PACK.
  assign in_cnt = (s_cnt_i == '0 || s_cnt_i > CNT_W'(NUM_PACK)) ? CNT_W'(NUM_PACK) : s_cnt_i;

  assign s_fire    = s_stb_i & s_cyc_i & ack_q;
  assign beat_fire = act_valid & d_ack_i;
  assign last_beat = beat_fire & (act_idx == act_cnt - CNT_W'(1));

  always_comb begin
    act_valid_n  = act_valid;
    act_dat_n    = act_dat;
    act_cnt_n    = act_cnt;
    act_tag_n    = act_tag;
    act_idx_n    = act_idx;
    pend_valid_n = pend_valid;
    pend_dat_n   = pend_dat;
    pend_cnt_n   = pend_cnt;
    pend_tag_n   = pend_tag;

    if (!act_valid || last_beat) begin
      // ACTIVE is free (or frees this edge): PENDING has priority, and a
      // word accepted alongside it takes PENDING's place.
      act_idx_n = '0;
      if (pend_valid) begin
        act_valid_n  = 1'b1;
        act_dat_n    = pend_dat;
        act_cnt_n    = pend_cnt;
        act_tag_n    = pend_tag;
        pend_valid_n = s_fire;
        if (s_fire) begin
          pend_dat_n = s_dat_i;
          pend_cnt_n = in_cnt;
          pend_tag_n = s_tgc_i;
        end
      end else if (s_fire) begin
        act_valid_n = 1'b1;
        act_dat_n   = s_dat_i;
        act_cnt_n   = in_cnt;
        act_tag_n   = s_tgc_i;
      end else begin
        act_valid_n = 1'b0;
      end
    end else begin
      if (beat_fire) begin
        act_idx_n = act_idx + CNT_W'(1);
      end
      if (s_fire) begin
        pend_valid_n = 1'b1;
        pend_dat_n   = s_dat_i;
        pend_cnt_n   = in_cnt;
        pend_tag_n   = s_tgc_i;
      end
    end

    // Registered accept keeps s_ack_o free of paths from d_ack_i / s_stb_i.
    ack_n = !pend_valid_n;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      act_valid  <= 1'b0;
      act_dat    <= '0;
      act_cnt    <= '0;
      act_tag    <= '0;
      act_idx    <= '0;
      pend_valid <= 1'b0;
      pend_dat   <= '0;
      pend_cnt   <= '0;
      pend_tag   <= '0;
      ack_q      <= 1'b0;
    end else begin
      act_valid  <= act_valid_n;
      act_dat    <= act_dat_n;
      act_cnt    <= act_cnt_n;
      act_tag    <= act_tag_n;
      act_idx    <= act_idx_n;
      pend_valid <= pend_valid_n;
      pend_dat   <= pend_dat_n;
      pend_cnt   <= pend_cnt_n;
      pend_tag   <= pend_tag_n;
      ack_q      <= ack_n;
    end
  end

  always_comb begin
    lane = 32'(act_idx);
    if (LITTLE_ENDIAN == 0) begin
      lane = NUM_PACK - 1 - lane;
    end
    d_dat_o = '0;
    for (int unsigned i = 0; i < NUM_PACK; i++) begin
      if (act_valid && lane == i) begin
        d_dat_o = act_dat[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    d_tgc_o = '0;
    if (act_valid) begin
      d_tgc_o    = act_tag;
      d_tgc_o[0] = act_tag[0] & (act_idx == '0);
      d_tgc_o[1] = act_tag[1] & (act_idx == act_cnt - CNT_W'(1));
    end
  end

  assign s_ack_o   = ack_q;
  assign s_stall_o = s_cyc_i & ~ack_q;
  assign d_stb_o   = act_valid;
  assign d_cyc_o   = act_valid;
  assign occ_o     = {1'b0, act_valid} + {1'b0, pend_valid};

endmodule
